multi_collision_scanner: RTL and testbench
==========================================

Name: multi_collision_scanner

Overview:
- Parametrised successor to the single-obstacle overlap checker. Tests one player box against N_OBS obstacle slots using one time-multiplexed AABB comparator, one slot per clock.
- Player has both X and Y position (supports jumping).
- Produces a per-slot hit vector, first-hit index, a per-frame collision flag and a sticky game-over latch.
- Sits between the obstacle generator / player controller and the game FSM; started once per video frame.

Parameters:
- COORD_W, 10, width of every coordinate/dimension
- N_OBS, 8, number of obstacle slots (2..32)
- PLAYER_WIDTH, 10'd30, player box width in pixels
- PLAYER_HEIGHT, 10'd30, player box height in pixels
- HIT_MARGIN, 10'd4, hitbox inset per side, used only when the optional feature is enabled

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- frame_tick  in  1  one-cycle pulse to start a scan
- player_x  in  COORD_W  player left edge
- player_y  in  COORD_W  player top edge
- obs_x_flat  in  N_OBS*COORD_W  obstacle left edges; slot i at [i*COORD_W +: COORD_W]
- obs_y_flat  in  N_OBS*COORD_W  obstacle top edges
- obs_w_flat  in  N_OBS*COORD_W  obstacle widths
- obs_h_flat  in  N_OBS*COORD_W  obstacle heights
- obs_valid  in  N_OBS  slot active mask
- clear_hit  in  1  clears the game_over latch
- busy  out  1  high while a scan is in progress
- scan_done  out  1  one-cycle pulse when results update
- hit_vec  out  N_OBS  per-slot hit result of the last completed scan
- collision  out  1  OR of hit_vec
- first_hit_idx  out  clog2(N_OBS)  lowest hit slot index; 0 when no hit
- game_over  out  1  sticky collision latch

Behaviour:
- Reset (rst_n low at a clk edge):
  - FSM goes to IDLE.
  - All outputs and internal registers go to 0.
  - Reset mid-scan aborts the scan; no scan_done is produced.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On frame_tick: snapshot player_x/player_y into registers, idx<=0, clear the working hit vector, go to SCAN, busy<=1.
- SCAN:
  - Each cycle evaluates slot idx combinationally from the live obstacle buses and the snapshotted player position.
  - Result is written to work_vec[idx].
  - If idx==N_OBS-1, go to DONE; otherwise idx<=idx+1.
- DONE (one cycle):
  - hit_vec<=work_vec; collision<=|work_vec; first_hit_idx<=lowest set index (0 if none).
  - scan_done pulses high for exactly this cycle; busy<=0; return to IDLE.
- Latency: frame_tick in cycle T gives scan_done and updated outputs visible in cycle T+N_OBS+2. busy is high for cycles T+1..T+N_OBS+1.
- frame_tick while busy is ignored. The scan is not restarted and nothing is queued.
- Obstacle buses must be held stable from frame_tick until scan_done. Player inputs are snapshotted and need not be held.
- Hit for slot i = obs_valid[i] AND all four strict inequalities:
  - px < ox+ow
  - px+PW > ox
  - py < oy+oh
  - py+PH > oy
- Edge-touching (equality) is not a hit.
- A slot with zero width or height can never hit.
- All sums are computed at COORD_W+1 bits, so right/bottom edges past 2^COORD_W-1 do not wrap.
- obs_valid is sampled at the evaluation cycle of its slot.
- game_over:
  - Set in the DONE cycle when collision of the new result is 1.
  - Cleared by clear_hit; when both occur in the same cycle, set wins.
  - Otherwise holds its value.
- hit_vec, collision and first_hit_idx hold their values between scans.

Optional Feature:
- Macro: HITBOX_MARGIN_EN.
- Defined: the player box is shrunk to px+HIT_MARGIN .. px+PW-HIT_MARGIN horizontally and py+HIT_MARGIN .. py+PH-HIT_MARGIN vertically in all four inequalities. This gives forgiving collisions. PW and PH must exceed 2*HIT_MARGIN.
- Undefined: the full PLAYER_WIDTH x PLAYER_HEIGHT box is used and HIT_MARGIN is unused.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles, then release -> all outputs 0, busy 0, no scan_done without frame_tick.
- Single hit, N_OBS=8: player (100,315); slot 5 = (120,320,20,20) valid; others invalid; tick at T -> scan_done at T+10, hit_vec=8'b0010_0000, collision=1, first_hit_idx=5, game_over=1.
- Edge touch: player (100,315); slot 0 = (130,315,10,30) -> no hit (px+30==ox). Move slot 0 to ox=129 -> hit.
- Multi-hit and mask: slots 2 and 6 overlapping; obs_valid[2]=0 -> hit_vec=8'b0100_0000, first_hit_idx=6. Set obs_valid[2]=1 -> first_hit_idx=2.
- Overflow/busy: slot at ox=1020, ow=10, player x=1000 -> hit, no wrap. Second frame_tick at T+3 ignored; exactly one scan_done.
- Latch and margin: clear_hit asserted in the same cycle as a DONE with collision -> game_over stays 1. With HITBOX_MARGIN_EN, obstacle overlapping player by 3 px -> no hit.

Source files
------------

// File: rtl/multi_collision_scanner.sv
// Time-multiplexed AABB scanner: one player box against N_OBS obstacle slots, one slot per clock.
// Optional forgiving hitbox inset enabled by defining HITBOX_MARGIN_EN.
module multi_collision_scanner #(
  parameter int                 COORD_W       = 10,
  parameter int                 N_OBS         = 8,
  parameter logic [COORD_W-1:0] PLAYER_WIDTH  = 10'd30,
  parameter logic [COORD_W-1:0] PLAYER_HEIGHT = 10'd30,
  parameter logic [COORD_W-1:0] HIT_MARGIN    = 10'd4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_tick,
  input  logic [COORD_W-1:0]         player_x,
  input  logic [COORD_W-1:0]         player_y,
  input  logic [N_OBS*COORD_W-1:0]   obs_x_flat,
  input  logic [N_OBS*COORD_W-1:0]   obs_y_flat,
  input  logic [N_OBS*COORD_W-1:0]   obs_w_flat,
  input  logic [N_OBS*COORD_W-1:0]   obs_h_flat,
  input  logic [N_OBS-1:0]           obs_valid,
  input  logic                       clear_hit,
  output logic                       busy,
  output logic                       scan_done,
  output logic [N_OBS-1:0]           hit_vec,
  output logic                       collision,
  output logic [$clog2(N_OBS)-1:0]   first_hit_idx,
  output logic                       game_over
);

  localparam int IDX_W = $clog2(N_OBS);
  localparam int EW    = COORD_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBS - 1);

`ifdef HITBOX_MARGIN_EN
  localparam bit MARGIN_ON = 1'b1;
`else
  localparam bit MARGIN_ON = 1'b0;
`endif
  localparam logic [COORD_W-1:0] EFF_MARGIN = MARGIN_ON ? HIT_MARGIN : '0;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state, state_next;
  logic [COORD_W-1:0] px_q, py_q;
  logic [IDX_W-1:0]   idx;
  logic [N_OBS-1:0]   work_vec;
  logic [IDX_W-1:0]   first_idx;
  logic               hit_now;

  logic [COORD_W-1:0] ox, oy, ow, oh;
  logic [EW-1:0]      p_left, p_right, p_top, p_bot;
  logic [EW-1:0]      o_left, o_right, o_top, o_bot;

  assign ox = obs_x_flat[idx*COORD_W +: COORD_W];
  assign oy = obs_y_flat[idx*COORD_W +: COORD_W];
  assign ow = obs_w_flat[idx*COORD_W +: COORD_W];
  assign oh = obs_h_flat[idx*COORD_W +: COORD_W];

  // All edges carry one extra bit so boxes near the screen edge never wrap around.
  assign p_left  = {1'b0, px_q} + {1'b0, EFF_MARGIN};
  assign p_right = {1'b0, px_q} + {1'b0, PLAYER_WIDTH} - {1'b0, EFF_MARGIN};
  assign p_top   = {1'b0, py_q} + {1'b0, EFF_MARGIN};
  assign p_bot   = {1'b0, py_q} + {1'b0, PLAYER_HEIGHT} - {1'b0, EFF_MARGIN};
  assign o_left  = {1'b0, ox};
  assign o_right = {1'b0, ox} + {1'b0, ow};
  assign o_top   = {1'b0, oy};
  assign o_bot   = {1'b0, oy} + {1'b0, oh};

  // Degenerate slots are rejected explicitly; the inequalities alone would accept them.
  assign hit_now = obs_valid[idx] && (ow != '0) && (oh != '0) &&
                   (p_left < o_right) && (p_right > o_left) &&
                   (p_top < o_bot) && (p_bot > o_top);

  always_comb begin
    first_idx = '0;
    for (int i = N_OBS - 1; i >= 0; i--) begin
      if (work_vec[i]) first_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_tick) state_next = SCAN;
      SCAN:    if (idx == LAST_IDX) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      px_q          <= '0;
      py_q          <= '0;
      idx           <= '0;
      work_vec      <= '0;
      busy          <= 1'b0;
      scan_done     <= 1'b0;
      hit_vec       <= '0;
      collision     <= 1'b0;
      first_hit_idx <= '0;
      game_over     <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            px_q     <= player_x;
            py_q     <= player_y;
            idx      <= '0;
            work_vec <= '0;
            busy     <= 1'b1;
          end
        end
        SCAN: begin
          work_vec[idx] <= hit_now;
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        DONE: begin
          hit_vec       <= work_vec;
          collision     <= |work_vec;
          first_hit_idx <= first_idx;
          scan_done     <= 1'b1;
          busy          <= 1'b0;
        end
        default: ;
      endcase
      // A fresh collision wins over a simultaneous clear request.
      if (state == DONE && (|work_vec)) game_over <= 1'b1;
      else if (clear_hit)               game_over <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_collision_scanner.sv
// Directed self-checking bench for multi_collision_scanner (default N_OBS=8, COORD_W=10).
// Margin expectations follow HITBOX_MARGIN_EN when the bench is built with it.
module tb_multi_collision_scanner;

  localparam int CW = 10;
  localparam int N  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            frame_tick;
  logic [CW-1:0]   player_x, player_y;
  logic [N*CW-1:0] obs_x_flat, obs_y_flat, obs_w_flat, obs_h_flat;
  logic [N-1:0]    obs_valid;
  logic            clear_hit;
  logic            busy, scan_done, collision, game_over;
  logic [N-1:0]    hit_vec;
  logic [2:0]      first_hit_idx;

  int total = 0;
  int bad   = 0;
  int lat, done_cnt, busy1;

  multi_collision_scanner dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .player_x(player_x), .player_y(player_y),
    .obs_x_flat(obs_x_flat), .obs_y_flat(obs_y_flat),
    .obs_w_flat(obs_w_flat), .obs_h_flat(obs_h_flat),
    .obs_valid(obs_valid), .clear_hit(clear_hit),
    .busy(busy), .scan_done(scan_done), .hit_vec(hit_vec),
    .collision(collision), .first_hit_idx(first_hit_idx), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setSlot(input int i, input int x, input int y, input int w, input int h);
    obs_x_flat[i*CW +: CW] = CW'(x);
    obs_y_flat[i*CW +: CW] = CW'(y);
    obs_w_flat[i*CW +: CW] = CW'(w);
    obs_h_flat[i*CW +: CW] = CW'(h);
  endtask

  task automatic clearSlots();
    obs_x_flat = '0; obs_y_flat = '0; obs_w_flat = '0; obs_h_flat = '0;
    obs_valid  = '0;
  endtask

  // Pulses frame_tick, optionally re-ticks and/or asserts clear_hit at given cycle offsets,
  // and reports the cycle offset of the first scan_done and how many pulses were seen.
  task automatic applyStimulus(input int tick2_at, input int clr_at, input int move_player,
                               output int latency, output int dones, output int busy_t1);
    latency = 0; dones = 0; busy_t1 = 0;
    frame_tick = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) begin
        frame_tick = 1'b0;
        busy_t1 = int'(busy);
        if (move_player != 0) begin player_x = 10'd600; player_y = 10'd5; end
      end
      if (k == tick2_at)     frame_tick = 1'b1;
      if (k == tick2_at + 1) frame_tick = 1'b0;
      if (k == clr_at)       clear_hit  = 1'b1;
      if (k == clr_at + 1)   clear_hit  = 1'b0;
      if (scan_done) begin
        if (latency == 0) latency = k;
        dones++;
      end
    end
    frame_tick = 1'b0;
    clear_hit  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; clear_hit = 1'b0;
    player_x = '0; player_y = '0;
    clearSlots();

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", scan_done, 0);
    checkOutput("reset_hitvec", hit_vec, 0);
    checkOutput("reset_coll", collision, 0);
    checkOutput("reset_first", first_hit_idx, 0);
    checkOutput("reset_gameover", game_over, 0);
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (scan_done) done_cnt++;
    end
    checkOutput("idle_no_done", done_cnt, 0);

    // Single hit in slot 5; player moves right after the tick to check the snapshot.
    player_x = 10'd100; player_y = 10'd315;
    setSlot(5, 120, 320, 20, 20); obs_valid = 8'b0010_0000;
    applyStimulus(0, 0, 1, lat, done_cnt, busy1);
    checkOutput("single_busy_t1", busy1, 1);
    checkOutput("single_latency", lat, 10);
    checkOutput("single_done_cnt", done_cnt, 1);
    checkOutput("single_hitvec", hit_vec, 32'h20);
    checkOutput("single_coll", collision, 1);
    checkOutput("single_first", first_hit_idx, 5);
    checkOutput("single_gameover", game_over, 1);
    checkOutput("single_busy_end", busy, 0);

    clear_hit = 1'b1; @(negedge clk); clear_hit = 1'b0;
    checkOutput("clear_gameover", game_over, 0);
    checkOutput("hold_hitvec", hit_vec, 32'h20);

    // Right edge touching: px+30 == ox is not a hit; one pixel further left is.
    clearSlots(); player_x = 10'd100; player_y = 10'd315;
    setSlot(0, 130, 315, 10, 30); obs_valid = 8'h01;
    applyStimulus(0, 0, 0, lat, done_cnt, busy1);
    checkOutput("edge_x_hitvec", hit_vec, 0);
    checkOutput("edge_x_coll", collision, 0);
    checkOutput("edge_x_first", first_hit_idx, 0);
    checkOutput("edge_x_gameover", game_over, 0);
    setSlot(0, 129, 315, 10, 30);
    applyStimulus(0, 0, 0, lat, done_cnt, busy1);
    checkOutput("edge_x1_hitvec", hit_vec, 32'h01);
    checkOutput("edge_x1_first", first_hit_idx, 0);

    // Bottom edge touching: py+30 == oy.
    setSlot(0, 110, 345, 10, 10);
    applyStimulus(0, 0, 0, lat, done_cnt, busy1);
    checkOutput("edge_y_hitvec", hit_vec, 0);

    // Zero-width slot well inside the player box.
    setSlot(0, 110, 320, 0, 10);
    applyStimulus(0, 0, 0, lat, done_cnt, busy1);
    checkOutput("zero_w_hitvec", hit_vec, 0);

    // Two overlapping slots, slot 2 masked then unmasked.
    clearSlots(); player_x = 10'd100; player_y = 10'd315;
    setSlot(2, 110, 320, 10, 10); setSlot(6, 90, 300, 20, 20);
    obs_valid = 8'b0100_0000;
    applyStimulus(0, 0, 0, lat, done_cnt, busy1);
    checkOutput("mask_hitvec", hit_vec, 32'h40);
    checkOutput("mask_first", first_hit_idx, 6);
    obs_valid = 8'b0100_0100;
    applyStimulus(0, 0, 0, lat, done_cnt, busy1);
    checkOutput("multi_hitvec", hit_vec, 32'h44);
    checkOutput("multi_first", first_hit_idx, 2);

    // Near the right screen edge, sums exceed 1023; a second tick mid-scan is ignored.
    clearSlots(); player_x = 10'd1000; player_y = 10'd315;
    setSlot(3, 1020, 315, 10, 10); obs_valid = 8'h08;
    clear_hit = 1'b1; @(negedge clk); clear_hit = 1'b0;
    applyStimulus(3, 0, 0, lat, done_cnt, busy1);
    checkOutput("ovf_hitvec", hit_vec, 32'h08);
    checkOutput("ovf_first", first_hit_idx, 3);
    checkOutput("busy_tick_done_cnt", done_cnt, 1);
    checkOutput("busy_tick_latency", lat, 10);

    // clear_hit in the DONE cycle of a colliding scan: the set wins.
    clear_hit = 1'b1; @(negedge clk); clear_hit = 1'b0;
    checkOutput("pre_latch_gameover", game_over, 0);
    applyStimulus(0, 9, 0, lat, done_cnt, busy1);
    checkOutput("latch_set_wins", game_over, 1);

    // Reset in the middle of a scan: no scan_done, everything back to zero.
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (scan_done) done_cnt++;
    end
    checkOutput("abort_done_cnt", done_cnt, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_hitvec", hit_vec, 0);
    checkOutput("abort_gameover", game_over, 0);

    // Obstacle overlapping the player's right side by 3 px.
    clearSlots(); player_x = 10'd100; player_y = 10'd315;
    setSlot(1, 127, 315, 10, 30); obs_valid = 8'h02;
    applyStimulus(0, 0, 0, lat, done_cnt, busy1);
`ifdef HITBOX_MARGIN_EN
    checkOutput("margin_hitvec", hit_vec, 0);
`else
    checkOutput("margin_hitvec", hit_vec, 32'h02);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
